// File: rtl/thread_pkg.sv
// Shared types for the thread control/status bank: per-thread state,
// command opcodes and error codes.
package thread_pkg;

    typedef enum logic [1:0] {
        TRD_FREE  = 2'd0,
        TRD_RUN   = 2'd1,
        TRD_SLEEP = 2'd2
    } trd_state_e;

    typedef enum logic [1:0] {
        CMD_INIT  = 2'd0,
        CMD_SLEEP = 2'd1,
        CMD_WAKE  = 2'd2,
        CMD_KILL  = 2'd3
    } trd_cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_NOT_PARENT = 2'd1,
        ERR_INIT_BUSY  = 2'd2,
        ERR_NOT_VALID  = 2'd3
    } trd_err_e;

    localparam logic [31:0] START_PC_DEF = 32'h0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping
// modulo N. Purely combinational so the fetch stage can reuse it.
module rr_arbiter #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] cand;
    logic         found;

    always_comb begin
        cand    = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vld = found;
    end

endmodule

// File: rtl/thread_csr_bank.sv
// Control/status bank for all hardware threads: state, parent and PC per
// thread, one checked command per cycle, round-robin run selection and a
// lowest-free-id allocator.
module thread_csr_bank
    import thread_pkg::*;
#(
    parameter int               NUM_TRD     = 8,
    parameter int               PC_W        = 32,
    parameter logic [PC_W-1:0]  START_PC    = PC_W'(START_PC_DEF),
    parameter bit               BOOT_TRD_EN = 1'b1,
    localparam int              TRD_W       = $clog2(NUM_TRD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_vld,
    input  logic [1:0]          cmd_op,
    input  logic [TRD_W-1:0]    cmd_obj,
    input  logic [TRD_W-1:0]    cmd_act,
    input  logic [PC_W-1:0]     cmd_pc,
    input  logic                pc_wr,
    input  logic [TRD_W-1:0]    pc_trd,
    input  logic [PC_W-1:0]     pc_nxt,
    input  logic                sched_adv,
    output logic                sel_vld,
    output logic [TRD_W-1:0]    sel_trd,
    output logic [PC_W-1:0]     sel_pc,
    output logic                free_vld,
    output logic [TRD_W-1:0]    free_trd,
    output logic [NUM_TRD-1:0]  trd_valid,
    output logic [NUM_TRD-1:0]  trd_running,
    output logic                err,
    output logic [1:0]          err_code
);

    localparam logic [TRD_W:0] NUM_TRD_V = (TRD_W + 1)'(NUM_TRD);

    trd_state_e [NUM_TRD-1:0]              state_vec;
    logic       [NUM_TRD-1:0][TRD_W-1:0]   parent_vec;
    logic       [NUM_TRD-1:0][PC_W-1:0]    pc_vec;

    trd_cmd_e            op;
    logic                obj_in_range;
    logic                act_in_range;
    trd_state_e          obj_state;
    logic [TRD_W-1:0]    obj_parent;
    trd_err_e            cmd_err;
    logic                cmd_ok;

    logic [TRD_W-1:0]    rr_ptr_reg;
    logic [TRD_W-1:0]    rr_ptr_next;
    logic [TRD_W-1:0]    arb_idx;
    logic                arb_vld;
    logic                err_reg;
    trd_err_e            err_code_reg;

    // ---------------- command decode and permission check ----------------
    assign op           = trd_cmd_e'(cmd_op);
    assign obj_in_range = {1'b0, cmd_obj} < NUM_TRD_V;
    assign act_in_range = {1'b0, cmd_act} < NUM_TRD_V;
    assign obj_state    = obj_in_range ? state_vec[cmd_obj]  : TRD_FREE;
    assign obj_parent   = obj_in_range ? parent_vec[cmd_obj] : '0;

    // Out-of-range ids are reported as NOT_VALID before any other check.
    always_comb begin
        cmd_err = ERR_NONE;
        if (!obj_in_range || !act_in_range) begin
            cmd_err = ERR_NOT_VALID;
        end else begin
            case (op)
                CMD_INIT: begin
                    if (obj_state != TRD_FREE)
                        cmd_err = ERR_INIT_BUSY;
                end
                CMD_WAKE: begin
                    if (obj_state == TRD_FREE)
                        cmd_err = ERR_NOT_VALID;
                end
                default: begin
                    if (obj_state == TRD_FREE)
                        cmd_err = ERR_NOT_VALID;
                    else if (obj_parent != cmd_act)
                        cmd_err = ERR_NOT_PARENT;
                end
            endcase
        end
    end

    assign cmd_ok = cmd_vld && (cmd_err == ERR_NONE);

    // ---------------- per-thread state, parent and PC ----------------
    for (genvar gi = 0; gi < NUM_TRD; gi++) begin : g_trd
        localparam trd_state_e RST_STATE =
            (BOOT_TRD_EN && gi == 0) ? TRD_RUN : TRD_FREE;

        trd_state_e          state_reg;
        trd_state_e          state_next;
        logic [TRD_W-1:0]    parent_reg;
        logic [PC_W-1:0]     pc_reg;
        logic                obj_hit;
        logic                pc_hit;

        assign obj_hit = cmd_ok && (cmd_obj == TRD_W'(gi));
        assign pc_hit  = pc_wr && (pc_trd == TRD_W'(gi)) && (state_reg != TRD_FREE);

        always_comb begin
            state_next = state_reg;
            if (obj_hit) begin
                case (op)
                    CMD_INIT:  state_next = TRD_RUN;
                    CMD_SLEEP: state_next = TRD_SLEEP;
                    CMD_WAKE:  state_next = TRD_RUN;
                    default:   state_next = TRD_FREE;
                endcase
            end
        end

        // A same-cycle INIT owns the PC; the pipeline write is dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg  <= RST_STATE;
                parent_reg <= '0;
                pc_reg     <= START_PC;
            end else begin
                state_reg <= state_next;
                if (obj_hit && op == CMD_INIT) begin
                    parent_reg <= cmd_act;
                    pc_reg     <= cmd_pc;
                end else if (pc_hit) begin
                    pc_reg <= pc_nxt;
                end
            end
        end

        assign state_vec[gi]   = state_reg;
        assign parent_vec[gi]  = parent_reg;
        assign pc_vec[gi]      = pc_reg;
        assign trd_valid[gi]   = (state_reg != TRD_FREE);
        assign trd_running[gi] = (state_reg == TRD_RUN);
    end

    // ---------------- round-robin scheduler ----------------
    rr_arbiter #(
        .N(NUM_TRD)
    ) u_rr (
        .req     (trd_running),
        .ptr     (rr_ptr_reg),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    assign sel_vld     = arb_vld;
    assign sel_trd     = arb_idx;
    assign sel_pc      = arb_vld ? pc_vec[arb_idx] : START_PC;
    assign rr_ptr_next = (arb_idx == TRD_W'(NUM_TRD - 1)) ? '0 : arb_idx + 1'b1;

    // ---------------- lowest-free allocator ----------------
    always_comb begin
        free_vld = 1'b0;
        free_trd = '0;
        for (int i = NUM_TRD - 1; i >= 0; i--) begin
            if (!trd_valid[i]) begin
                free_vld = 1'b1;
                free_trd = TRD_W'(i);
            end
        end
    end

    // ---------------- error reporting and pointer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg   <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            err_reg <= cmd_vld && (cmd_err != ERR_NONE);
            if (cmd_vld)
                err_code_reg <= cmd_err;
            if (sched_adv && arb_vld)
                rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_thread_csr_bank.sv
// Scoreboard bench: two banks (8 and 6 threads) share one stimulus stream;
// a thread-level reference model predicts outputs, a monitor compares.
module tb_thread_csr_bank;

    localparam int N0 = 8;
    localparam int N1 = 6;

    localparam int ST_FREE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_SLEEP = 2;

    localparam int OP_INIT  = 0;
    localparam int OP_SLEEP = 1;
    localparam int OP_WAKE  = 2;
    localparam int OP_KILL  = 3;

    localparam int E_NOT_PARENT = 1;
    localparam int E_INIT_BUSY  = 2;
    localparam int E_NOT_VALID  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_obj = '0;
    logic [2:0]  cmd_act = '0;
    logic [31:0] cmd_pc = '0;
    logic        pc_wr = 1'b0;
    logic [2:0]  pc_trd = '0;
    logic [31:0] pc_nxt = '0;
    logic        sched_adv = 1'b0;

    logic        d0_sel_vld, d0_free_vld, d0_err;
    logic [2:0]  d0_sel_trd, d0_free_trd;
    logic [31:0] d0_sel_pc;
    logic [7:0]  d0_valid, d0_running;
    logic [1:0]  d0_code;

    logic        d1_sel_vld, d1_free_vld, d1_err;
    logic [2:0]  d1_sel_trd, d1_free_trd;
    logic [31:0] d1_sel_pc;
    logic [5:0]  d1_valid, d1_running;
    logic [1:0]  d1_code;

    always #5 clk = ~clk;

    thread_csr_bank #(.NUM_TRD(N0)) dut0 (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_op(cmd_op),
        .cmd_obj(cmd_obj), .cmd_act(cmd_act), .cmd_pc(cmd_pc),
        .pc_wr(pc_wr), .pc_trd(pc_trd), .pc_nxt(pc_nxt), .sched_adv(sched_adv),
        .sel_vld(d0_sel_vld), .sel_trd(d0_sel_trd), .sel_pc(d0_sel_pc),
        .free_vld(d0_free_vld), .free_trd(d0_free_trd),
        .trd_valid(d0_valid), .trd_running(d0_running),
        .err(d0_err), .err_code(d0_code)
    );

    thread_csr_bank #(.NUM_TRD(N1)) dut1 (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_op(cmd_op),
        .cmd_obj(cmd_obj), .cmd_act(cmd_act), .cmd_pc(cmd_pc),
        .pc_wr(pc_wr), .pc_trd(pc_trd), .pc_nxt(pc_nxt), .sched_adv(sched_adv),
        .sel_vld(d1_sel_vld), .sel_trd(d1_sel_trd), .sel_pc(d1_sel_pc),
        .free_vld(d1_free_vld), .free_trd(d1_free_trd),
        .trd_valid(d1_valid), .trd_running(d1_running),
        .err(d1_err), .err_code(d1_code)
    );

    typedef struct {
        bit          sel_vld;
        int          sel_trd;
        logic [31:0] sel_pc;
        bit          free_vld;
        int          free_trd;
        logic [15:0] valid;
        logic [15:0] running;
        bit          err;
        int          code;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int          m_st  [2][16];
    int          m_par [2][16];
    logic [31:0] m_pc  [2][16];
    int          m_ptr [2];
    bit          m_err [2];
    int          m_code[2];

    int checks = 0;
    int errors = 0;
    int txn = 0;

    // ---------------- reference model ----------------
    function automatic int find_run(int k, int n);
        int s = -1;
        for (int i = 0; i < n; i++) begin
            int t = (m_ptr[k] + i) % n;
            if (s < 0 && m_st[k][t] == ST_RUN) s = t;
        end
        return s;
    endfunction

    task automatic model_step(int k, int n, bit r, bit v, int op, int obj, int act,
                              logic [31:0] cpc, bit pw, int pt, logic [31:0] pn, bit adv);
        int code;
        int sel;
        bit legal_init;
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_st[k][i] = ST_FREE; m_par[k][i] = 0; m_pc[k][i] = 32'h0;
            end
            m_st[k][0] = ST_RUN;
            m_ptr[k] = 0; m_err[k] = 0; m_code[k] = 0;
            return;
        end
        sel  = find_run(k, n);
        code = 0;
        if (v) begin
            if (obj >= n || act >= n) code = E_NOT_VALID;
            else if (op == OP_INIT) begin
                if (m_st[k][obj] != ST_FREE) code = E_INIT_BUSY;
            end
            else if (m_st[k][obj] == ST_FREE) code = E_NOT_VALID;
            else if (op != OP_WAKE && m_par[k][obj] != act) code = E_NOT_PARENT;
        end
        legal_init = v && code == 0 && op == OP_INIT;
        if (pw && pt < n && m_st[k][pt] != ST_FREE && !(legal_init && obj == pt))
            m_pc[k][pt] = pn;
        if (v && code == 0) begin
            case (op)
                OP_INIT:  begin m_st[k][obj] = ST_RUN; m_par[k][obj] = act; m_pc[k][obj] = cpc; end
                OP_SLEEP: m_st[k][obj] = ST_SLEEP;
                OP_WAKE:  m_st[k][obj] = ST_RUN;
                default:  m_st[k][obj] = ST_FREE;
            endcase
        end
        m_err[k] = v && code != 0;
        if (v) m_code[k] = code;
        if (adv && sel >= 0) m_ptr[k] = (sel + 1) % n;
    endtask

    function automatic exp_t expect_out(int k, int n);
        exp_t e;
        int sel = find_run(k, n);
        e.sel_vld  = sel >= 0;
        e.sel_trd  = (sel >= 0) ? sel : 0;
        e.sel_pc   = (sel >= 0) ? m_pc[k][sel] : 32'h0;
        e.free_vld = 0;
        e.free_trd = 0;
        e.valid    = '0;
        e.running  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (m_st[k][i] == ST_FREE) begin e.free_vld = 1; e.free_trd = i; end
            e.valid[i]   = m_st[k][i] != ST_FREE;
            e.running[i] = m_st[k][i] == ST_RUN;
        end
        e.err  = m_err[k];
        e.code = m_code[k];
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic step(bit r, bit v, int op, int obj, int act, logic [31:0] cpc,
                        bit pw, int pt, logic [31:0] pn, bit adv);
        @(negedge clk);
        rst = r; cmd_vld = v; cmd_op = 2'(op); cmd_obj = 3'(obj); cmd_act = 3'(act);
        cmd_pc = cpc; pc_wr = pw; pc_trd = 3'(pt); pc_nxt = pn; sched_adv = adv;
        model_step(0, N0, r, v, op, obj, act, cpc, pw, pt, pn, adv);
        model_step(1, N1, r, v, op, obj, act, cpc, pw, pt, pn, adv);
        q0.push_back(expect_out(0, N0));
        q1.push_back(expect_out(1, N1));
    endtask

    task automatic cmd(int op, int obj, int act, logic [31:0] cpc, bit adv);
        step(0, 1, op, obj, act, cpc, 0, 0, 32'h0, adv);
    endtask

    task automatic idle(bit adv);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, adv);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(string name, int k, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d txn %0d: got=0x%0h want=0x%0h", name, k, txn, got, want);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("sel_vld",  0, 32'(d0_sel_vld),  32'(e0.sel_vld));
                chk("sel_trd",  0, 32'(d0_sel_trd),  32'(e0.sel_trd));
                chk("sel_pc",   0, d0_sel_pc,        e0.sel_pc);
                chk("free_vld", 0, 32'(d0_free_vld), 32'(e0.free_vld));
                chk("free_trd", 0, 32'(d0_free_trd), 32'(e0.free_trd));
                chk("trd_valid",   0, 32'(d0_valid),   32'(e0.valid));
                chk("trd_running", 0, 32'(d0_running), 32'(e0.running));
                chk("err",      0, 32'(d0_err),      32'(e0.err));
                chk("err_code", 0, 32'(d0_code),     32'(e0.code));
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("sel_vld",  1, 32'(d1_sel_vld),  32'(e1.sel_vld));
                chk("sel_trd",  1, 32'(d1_sel_trd),  32'(e1.sel_trd));
                chk("sel_pc",   1, d1_sel_pc,        e1.sel_pc);
                chk("free_vld", 1, 32'(d1_free_vld), 32'(e1.free_vld));
                chk("free_trd", 1, 32'(d1_free_trd), 32'(e1.free_trd));
                chk("trd_valid",   1, 32'(d1_valid),   32'(e1.valid));
                chk("trd_running", 1, 32'(d1_running), 32'(e1.running));
                chk("err",      1, 32'(d1_err),      32'(e1.err));
                chk("err_code", 1, 32'(d1_code),     32'(e1.code));
                $display("txn %0d: sel=%0d/%0d pc=%h free=%0d valid=%h/%h err=%0d code=%0d/%0d",
                         txn, d0_sel_trd, d1_sel_trd, d0_sel_pc, d0_free_trd,
                         d0_valid, d1_valid, d0_err, d0_code, d1_code);
                txn++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int op, obj, act;
        step(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        idle(0);

        cmd(OP_INIT, 3, 0, 32'h100, 0);
        cmd(OP_INIT, 3, 0, 32'h999, 0);
        idle(0);
        cmd(OP_SLEEP, 3, 1, 32'h0, 0);
        cmd(OP_SLEEP, 3, 0, 32'h0, 0);
        cmd(OP_WAKE, 3, 5, 32'h0, 0);
        cmd(OP_KILL, 3, 0, 32'h0, 0);

        cmd(OP_INIT, 2, 0, 32'h20, 0);
        cmd(OP_INIT, 5, 0, 32'h50, 0);
        idle(1); idle(1); idle(1); idle(1);
        cmd(OP_SLEEP, 2, 0, 32'h0, 1);
        idle(1); idle(1);

        step(0, 1, OP_INIT, 4, 0, 32'h200, 1, 4, 32'h300, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1, 6, 32'hdead, 0);
        for (int i = 0; i < 6; i++) idle(1);

        cmd(OP_INIT, 1, 0, 32'h10, 0);
        cmd(OP_INIT, 3, 0, 32'h30, 0);
        cmd(OP_INIT, 6, 0, 32'h60, 0);
        cmd(OP_INIT, 7, 0, 32'h70, 0);
        cmd(OP_INIT, 6, 1, 32'h61, 0);
        cmd(OP_KILL, 7, 0, 32'h0, 0);
        cmd(OP_WAKE, 6, 7, 32'h0, 0);

        step(1, 1, OP_KILL, 0, 0, 32'h0, 1, 0, 32'h55, 1);
        idle(0);

        for (int i = 0; i < 500; i++) begin
            op  = $urandom_range(3, 0);
            obj = $urandom_range(7, 0);
            act = ($urandom_range(1, 0) == 1) ? m_par[0][obj] : $urandom_range(7, 0);
            step(($urandom_range(99, 0) == 0), ($urandom_range(9, 0) < 6), op, obj, act,
                 $urandom, ($urandom_range(9, 0) < 3), $urandom_range(7, 0), $urandom,
                 $urandom_range(1, 0) == 1);
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", 0, 32'(q0.size() + q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
